// File: rtl/exec_pkg.sv
// exec_pkg: shared ALU/condition codes, cc layout, reset cc value and buffer states.
package exec_pkg;
   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_fun_e;
   typedef enum logic [3:0] {C_ALW, C_LE, C_L, C_E, C_NE, C_GE, C_G} ifun_e;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;
   localparam logic [2:0] CC_RESET = 3'b100;
endpackage

// File: rtl/cc_eval.sv
// cc_eval: next flags from the ALU beat and condition from the current cc.
// Overflow tracking is enabled by defining EXEC_CC_OVF_EN.
module cc_eval
   import exec_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_res,
   input  logic [1:0]       alu_fun,
   input  logic [3:0]       ifun,
   input  logic [2:0]       cc,
   output logic [2:0]       cc_next,
   output logic             cnd
);
`ifdef EXEC_CC_OVF_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif
   logic sa, sb, sr, raw_of, lt, zf;
   assign sa = alu_a[WIDTH-1];
   assign sb = alu_b[WIDTH-1];
   assign sr = alu_res[WIDTH-1];
   assign raw_of = (alu_fun == ALU_ADD) ? (sa == sb) && (sr != sa) :
                   (alu_fun == ALU_SUB) ? (sa != sb) && (sr != sb) : 1'b0;
   assign cc_next = {alu_res == '0, sr, OVF_EN && raw_of};
   // without overflow tracking the signed conditions collapse to SF alone
   assign lt = cc[CC_SF] ^ (OVF_EN && cc[CC_OF]);
   assign zf = cc[CC_ZF];
   always_comb begin
      cnd = 1'b0;
      case (ifun)
         C_ALW:   cnd = 1'b1;
         C_LE:    cnd = lt | zf;
         C_L:     cnd = lt;
         C_E:     cnd = zf;
         C_NE:    cnd = ~zf;
         C_GE:    cnd = ~lt;
         C_G:     cnd = ~lt & ~zf;
         default: cnd = 1'b0;
      endcase
   end
endmodule

// File: rtl/exec_cc_stage.sv
// exec_cc_stage: execute-stage result/condition register with a 2-entry skid buffer.
// Head entry drives the outputs directly; EXEC_CC_OVF_EN enables OF in cc_eval.
module exec_cc_stage
   import exec_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_res,
   input  logic [1:0]       alu_fun,
   input  logic [3:0]       ifun,
   input  logic             set_cc,
   input  logic             bubble,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_res,
   output logic             out_cnd,
   output logic [2:0]       cc
);
   if (DEPTH != 2) begin : g_depth
      $error("exec_cc_stage supports DEPTH=2 only");
   end
   state_e state, state_nx;
   logic acc, emit, cnd, sk_cnd, new_cnd;
   logic [2:0] cc_nx;
   logic [WIDTH-1:0] sk_res, new_res;
   cc_eval #(.WIDTH(WIDTH)) u_cc (
      .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res), .alu_fun(alu_fun),
      .ifun(ifun), .cc(cc), .cc_next(cc_nx), .cnd(cnd)
   );
   assign in_ready = state != TWO;
   assign out_valid = state != EMPTY;
   assign acc = in_valid && in_ready;
   assign emit = out_valid && out_ready;
   assign new_res = bubble ? '0 : alu_res;
   assign new_cnd = !bubble && cnd;
   always_comb begin
      state_nx = state;
      if (acc && !emit) state_nx = (state == EMPTY) ? ONE : TWO;
      else if (!acc && emit) state_nx = (state == TWO) ? ONE : EMPTY;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= EMPTY;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_res <= '0;
         out_cnd <= 1'b0;
         sk_res  <= '0;
         sk_cnd  <= 1'b0;
         cc      <= CC_RESET;
      end else begin
         if (acc && set_cc && !bubble) cc <= cc_nx;
         // head takes the new beat when it is free or draining this cycle
         if ((state == EMPTY && acc) || (state == ONE && acc && emit)) begin
            out_res <= new_res;
            out_cnd <= new_cnd;
         end else if (state == TWO && emit) begin
            out_res <= sk_res;
            out_cnd <= sk_cnd;
         end
         if (state == ONE && acc && !emit) begin
            sk_res <= new_res;
            sk_cnd <= new_cnd;
         end
      end
   end
endmodule

// File: tb/tb_exec_cc_stage.sv
// tb_exec_cc_stage: directed checks of exec_cc_stage flags, conditions and buffering.
module tb_exec_cc_stage;
   logic clk = 1'b0;
   logic rst_n, in_valid, in_ready, set_cc, bubble, out_ready, out_valid, out_cnd;
   logic [63:0] alu_a, alu_b, alu_res, out_res;
   logic [1:0] alu_fun;
   logic [3:0] ifun;
   logic [2:0] cc;
   int total = 0;
   int bad = 0;
`ifdef EXEC_CC_OVF_EN
   localparam logic [2:0] CC_OVF = 3'b011;
   localparam logic CND_L = 1'b0;
   localparam logic CND_GE = 1'b1;
`else
   localparam logic [2:0] CC_OVF = 3'b010;
   localparam logic CND_L = 1'b1;
   localparam logic CND_GE = 1'b0;
`endif
   localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

   exec_cc_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res), .alu_fun(alu_fun),
      .ifun(ifun), .set_cc(set_cc), .bubble(bubble), .out_ready(out_ready),
      .out_valid(out_valid), .out_res(out_res), .out_cnd(out_cnd), .cc(cc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] r, input logic [3:0] i, input logic s, input logic bb);
      in_valid = 1'b1;
      alu_fun = f;
      alu_a = a;
      alu_b = b;
      alu_res = r;
      ifun = i;
      set_cc = s;
      bubble = bb;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      alu_a = '0;
      alu_b = '0;
      alu_res = '0;
      alu_fun = 2'd0;
      ifun = 4'd0;
      set_cc = 1'b0;
      bubble = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_res", out_res, 64'd0);
      chk("rst_cnd", out_cnd, 1'b0);
      chk("rst_cc", cc, 3'b100);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", in_ready, 1'b1);

      beat(2'd2, MAXP, 64'd2, 64'd2, 4'd0, 1'b1, 1'b0);
      chk("and_valid", out_valid, 1'b1);
      chk("and_res", out_res, 64'd2);
      chk("and_cnd", out_cnd, 1'b1);
      chk("and_cc", cc, 3'b000);

      beat(2'd0, MAXP, MAXP, 64'hFFFF_FFFF_FFFF_FFFE, 4'd3, 1'b1, 1'b0);
      chk("add_res", out_res, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("add_cnd_e", out_cnd, 1'b0);
      chk("add_cc", cc, CC_OVF);

      beat(2'd2, 64'h11, 64'h11, 64'h11, 4'd2, 1'b0, 1'b0);
      chk("l_cnd", out_cnd, CND_L);
      chk("l_res", out_res, 64'h11);
      chk("hold_cc", cc, CC_OVF);

      beat(2'd1, 64'd5, 64'd5, 64'd0, 4'd5, 1'b1, 1'b0);
      chk("ge_cnd", out_cnd, CND_GE);
      chk("sub_cc", cc, 3'b100);

      beat(2'd3, 64'd3, 64'd4, 64'd7, 4'd3, 1'b0, 1'b0);
      chk("e_cnd", out_cnd, 1'b1);
      beat(2'd2, MSB, MSB, MSB, 4'd4, 1'b1, 1'b0);
      chk("ne_cnd", out_cnd, 1'b0);
      chk("neg_cc", cc, 3'b010);

      beat(2'd0, 64'd0, 64'd0, 64'd0, 4'd0, 1'b1, 1'b1);
      chk("bub_valid", out_valid, 1'b1);
      chk("bub_res", out_res, 64'd0);
      chk("bub_cnd", out_cnd, 1'b0);
      chk("bub_cc", cc, 3'b010);
      idle();
      chk("drain_valid", out_valid, 1'b0);

      beat(2'd2, 64'd1, 64'd1, 64'd1, 4'd1, 1'b0, 1'b0);
      chk("le_cnd", out_cnd, 1'b1);
      beat(2'd2, 64'd1, 64'd1, 64'd1, 4'd6, 1'b0, 1'b0);
      chk("g_cnd", out_cnd, 1'b0);
      beat(2'd2, 64'd1, 64'd1, 64'd1, 4'd9, 1'b0, 1'b0);
      chk("ifun9_cnd", out_cnd, 1'b0);
      idle();

      out_ready = 1'b0;
      beat(2'd2, 64'd0, 64'd0, 64'hA1, 4'd0, 1'b0, 1'b0);
      chk("bp_a_res", out_res, 64'hA1);
      chk("bp_a_ready", in_ready, 1'b1);
      beat(2'd2, 64'd0, 64'd0, 64'hB2, 4'd0, 1'b0, 1'b0);
      chk("bp_b_res", out_res, 64'hA1);
      chk("bp_b_ready", in_ready, 1'b0);
      beat(2'd2, 64'd0, 64'd0, 64'hC3, 4'd0, 1'b0, 1'b0);
      chk("bp_c_res", out_res, 64'hA1);
      chk("bp_c_ready", in_ready, 1'b0);
      chk("bp_c_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      idle();
      chk("bp_pop_res", out_res, 64'hB2);
      chk("bp_pop_ready", in_ready, 1'b1);
      chk("bp_pop_valid", out_valid, 1'b1);
      idle();
      chk("bp_empty", out_valid, 1'b0);

      out_ready = 1'b0;
      beat(2'd2, MSB, MSB, MSB, 4'd0, 1'b1, 1'b0);
      beat(2'd2, 64'd0, 64'd0, 64'h33, 4'd0, 1'b0, 1'b0);
      chk("full_ready", in_ready, 1'b0);
      chk("full_cc", cc, 3'b010);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", out_valid, 1'b0);
      chk("mrst_cc", cc, 3'b100);
      chk("mrst_res", out_res, 64'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      beat(2'd2, 64'd0, 64'd0, 64'h44, 4'd3, 1'b0, 1'b0);
      chk("post_res", out_res, 64'h44);
      chk("post_cnd", out_cnd, 1'b1);
      idle();
      chk("post_empty", out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/exec_cc_stage.md
EXEC_CC_STAGE -- requirements
Module: exec_cc_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 64: ALU operand and result width.
REQ-002 SHALL have parameter DEPTH, default 2: skid-buffer entries, fixed at 2; other values unsupported.
REQ-003 SHALL have port clk  input  1: sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: ALU result presented.
REQ-006 SHALL have port in_ready  output  1: stage can accept.
REQ-007 SHALL have ports alu_a, alu_b  input  WIDTH: ALU operands as driven to the ALU.
REQ-008 SHALL have port alu_res  input  WIDTH: ALU output for alu_a/alu_b.
REQ-009 SHALL have port alu_fun  input  2: 0 add (b+a), 1 sub (b-a), 2 and, 3 xor.
REQ-010 SHALL have port ifun  input  4: condition select for cnd.
REQ-011 SHALL have port set_cc  input  1: this op updates condition codes.
REQ-012 SHALL have port bubble  input  1: accepted beat becomes a no-op.
REQ-013 SHALL have port out_ready  input  1: memory stage accepts.
REQ-014 SHALL have ports out_valid  output  1; out_res  output  WIDTH; out_cnd  output  1: registered result and condition.
REQ-015 SHALL have port cc  output  3: {ZF,SF,OF} register.

Function
REQ-016 SHALL accept a beat on in_valid&&in_ready, emit on out_valid&&out_ready; all outputs registered.
REQ-017 SHALL implement FSM EMPTY/ONE/TWO = entries held; accept-only +1, emit-only -1, simultaneous accept+emit holds count.
REQ-018 SHALL drive in_ready = (state!=TWO), from state register only, never from out_ready combinationally.
REQ-019 SHALL give latency of exactly one cycle from accept to out_valid when EMPTY.
REQ-020 SHALL emit in accept order; no entry dropped or duplicated at full/empty boundaries.
REQ-021 SHALL compute ZF=(alu_res==0), SF=alu_res[WIDTH-1].
REQ-022 SHALL compute OF: add = a,b same sign and res sign differs from a; sub = a,b sign differ and res sign differs from b; and/xor = 0.
REQ-023 SHALL update cc on accept only when set_cc=1 and bubble=0; otherwise cc holds.
REQ-024 SHALL evaluate cnd from cc value before this beat's update: 0 always=1, 1 le=(SF^OF)|ZF, 2 l=SF^OF, 3 e=ZF, 4 ne=~ZF, 5 ge=~(SF^OF), 6 g=~(SF^OF)&~ZF, 7-15 = 0.
REQ-025 SHALL store bubble beats with res=0, cnd=0, still occupying an entry and emitted as valid.
REQ-026 SHALL ignore in_valid inputs whenever in_ready=0.

Reset
REQ-027 SHALL on rst_n low, immediately: state EMPTY, out_valid 0, out_res 0, out_cnd 0, cc 3'b100 (ZF=1), in_ready 1 after release.
REQ-028 SHALL discard buffered entries on reset mid-operation; first beat after release sees cc=3'b100.

Configuration
REQ-029 SHALL honour macro EXEC_CC_OVF_EN: defined, OF computed per REQ-022; undefined, OF hard-wired 0 and signed conditions reduce to SF-only.

Structure
REQ-030 SHALL place alu_fun codes, ifun codes, cc bit indices and reset cc value in shared package exec_pkg.
REQ-031 SHALL isolate flag/condition logic in one combinational sub-module cc_eval; buffer/FSM in exec_cc_stage.

Verification
REQ-032 SHALL cover and: a=0x7FFFFFFFFFFFFFFF, b=2, res=2, set_cc=1 -> out_res=2, next cc=000.
REQ-033 SHALL cover add overflow: a=b=0x7FFFFFFFFFFFFFFF, res=0xFFFFFFFFFFFFFFFE, set_cc -> cc=011 (macro on), 010 (off); following ifun=2 -> cnd=0 (on), 1 (off).
REQ-034 SHALL cover sub zero: a=b=5, res=0, set_cc -> cc=100; next beat ifun=3 -> cnd=1, ifun=4 -> cnd=0.
REQ-035 SHALL cover backpressure: out_ready=0, three beats offered -> two accepted, in_ready=0; out_ready=1 -> emitted in order, in_ready=1 next cycle.
REQ-036 SHALL cover bubble: bubble=1, set_cc=1, res=0 -> cc unchanged, out_res=0, out_cnd=0.
REQ-037 SHALL cover reset mid-run: rst_n low with state TWO -> out_valid=0, cc=100 same cycle.
